// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) shared constants, types and encode function
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    // Even-parity bit positions inside the codeword.
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P4_IDX = 3;

    // Codeword positions of payload bits d0..d3.
    localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6};

    typedef logic [CODE_W-1:0] code_t;

    // Clean encode; each parity bit covers the positions whose 1-based index
    // has the matching bit set, so the corrector's syndrome names the bad bit.
    function automatic code_t hamming_encode(input logic [DATA_W-1:0] data);
        code_t c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c[DATA_POS[i]] = data[i];
        end
        c[P1_IDX] = c[2] ^ c[4] ^ c[6];
        c[P2_IDX] = c[2] ^ c[5] ^ c[6];
        c[P4_IDX] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - one-entry valid/ready skid buffer with registered ready
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_tvalid_i/s_tready_o/s_tdata_i   upstream stream
//   m_tvalid_o/m_tready_i/m_tdata_o   downstream stream (registered)
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_tvalid_i,
    output logic         s_tready_o,
    input  logic [W-1:0] s_tdata_i,
    output logic         m_tvalid_o,
    input  logic         m_tready_i,
    output logic [W-1:0] m_tdata_o
);

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         skid_valid_q;
    logic [W-1:0] skid_data_q;
    logic         ready_q;

    logic in_fire;
    logic out_fire;
    logic skid_valid_d;

    assign in_fire  = s_tvalid_i && ready_q;
    assign out_fire = out_valid_q && m_tready_i;

    // Skid only fills when a word arrives while the output is stalled, and
    // only empties when the output fires.
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (skid_valid_q && out_fire) begin
            skid_valid_d = 1'b0;
        end else if (!skid_valid_q && in_fire && out_valid_q && !m_tready_i) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            if (skid_valid_q) begin
                // ready_q is low here, so no input transfer can collide.
                if (out_fire) begin
                    out_data_q <= skid_data_q;
                end
            end else if (in_fire) begin
                if (!out_valid_q || m_tready_i) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= s_tdata_i;
                end else begin
                    skid_data_q <= s_tdata_i;
                end
            end else if (out_fire) begin
                // Data is left in place so it never goes unknown while idle.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign s_tready_o = ready_q;
    assign m_tvalid_o = out_valid_q;
    assign m_tdata_o  = out_data_q;

endmodule

// File: rtl/hamming74_encoder.sv
// rtl/hamming74_encoder.sv - Hamming(7,4) encoder with fault injection and stats
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_data       4-bit payload stream
//   inj_en, inj_pos                 flip codeword bit inj_pos-1 (pos 0 = none)
//   out_valid/out_ready/out_data    7-bit codeword stream, 1-cycle latency
//   word_cnt, inj_cnt               saturating delivered / corrupted counts
module hamming74_encoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  inj_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        inj_tag;
    code_t       flip_mask;
    code_t       code_enc;
    logic [CODE_W:0] m_tdata;
    logic        m_tvalid;

    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

    // Parity is formed on clean data, then the selected bit is corrupted so
    // the downstream corrector sees a genuine single-bit error.
    assign inj_tag   = inj_en && (inj_pos != 3'd0);
    assign flip_mask = inj_tag ? (code_t'(1) << (inj_pos - 3'd1)) : '0;
    assign code_enc  = hamming_encode(in_data) ^ flip_mask;

    skid_buffer #(
        .W(CODE_W + 1)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tvalid_i (in_valid),
        .s_tready_o (in_ready),
        .s_tdata_i  ({inj_tag, code_enc}),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (out_ready),
        .m_tdata_o  (m_tdata)
    );

    always_comb begin
        word_cnt_d = word_cnt_q;
        inj_cnt_d  = inj_cnt_q;
        if (m_tvalid && out_ready) begin
            if (word_cnt_q != CNT_MAX) begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end
            if (m_tdata[CODE_W] && (inj_cnt_q != CNT_MAX)) begin
                inj_cnt_d = inj_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            inj_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            inj_cnt_q  <= inj_cnt_d;
        end
    end

    assign out_valid = m_tvalid;
    assign out_data  = m_tdata[CODE_W-1:0];
    assign word_cnt  = word_cnt_q;
    assign inj_cnt   = inj_cnt_q;

endmodule

// File: tb/tb_hamming74_encoder.sv
// tb/tb_hamming74_encoder.sv - self-checking bench for hamming74_encoder
module tb_hamming74_encoder;
    import hamming_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       inj_en;
    logic [2:0] inj_pos;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic [15:0] word_cnt;
    logic [15:0] inj_cnt;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [6:0] s_out_data;
    logic [3:0] s_word_cnt;
    logic [3:0] s_inj_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    code_t exp_q[$];

    always #5 clk = ~clk;

    hamming74_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .word_cnt(word_cnt), .inj_cnt(inj_cnt)
    );

    hamming74_encoder #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .word_cnt(s_word_cnt), .inj_cnt(s_inj_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic code_t model(input logic [3:0] d, input logic en, input logic [2:0] pos);
        code_t c;
        c = hamming_encode(d);
        if (en && pos != 3'd0) c[pos - 3'd1] = ~c[pos - 3'd1];
        return c;
    endfunction

    // Scoreboard: handshakes are stable mid-cycle, so evaluate them at negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", int'(out_data), -1);
                end else begin
                    check("sb_order", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, inj_en, inj_pos));
        end
    end

    typedef struct {
        logic [3:0] d;
        logic       en;
        logic [2:0] pos;
        logic [6:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[11];
        int   n_inj;
        tbl[0]  = '{4'hB, 1'b0, 3'd0, 7'h55};
        tbl[1]  = '{4'h0, 1'b0, 3'd0, 7'h00};
        tbl[2]  = '{4'h1, 1'b0, 3'd0, 7'h07};
        tbl[3]  = '{4'hF, 1'b0, 3'd0, 7'h7F};
        tbl[4]  = '{4'hB, 1'b1, 3'd5, 7'h45};
        tbl[5]  = '{4'hB, 1'b1, 3'd0, 7'h55};
        tbl[6]  = '{4'h2, 1'b0, 3'd0, 7'h19};
        tbl[7]  = '{4'h4, 1'b0, 3'd0, 7'h2A};
        tbl[8]  = '{4'h8, 1'b0, 3'd0, 7'h4B};
        tbl[9]  = '{4'h0, 1'b1, 3'd1, 7'h01};
        tbl[10] = '{4'hF, 1'b1, 3'd7, 7'h3F};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        inj_en = 1'b0; inj_pos = '0; out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_word_cnt", int'(word_cnt), 0);
        check("rst_inj_cnt", int'(inj_cnt), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", int'(in_ready), 1);

        // Table-driven back-to-back stream with out_ready held high.
        n_inj = 0;
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) begin
                check($sformatf("tbl%0d_valid", i-1), int'(out_valid), 1);
                check($sformatf("tbl%0d_data", i-1), int'(out_data), int'(tbl[i-1].exp));
            end
            if (i < 11) begin
                check($sformatf("tbl%0d_in_ready", i), int'(in_ready), 1);
                in_valid = 1'b1; in_data = tbl[i].d;
                inj_en = tbl[i].en; inj_pos = tbl[i].pos;
                if (tbl[i].en && tbl[i].pos != 0) n_inj++;
            end else begin
                in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0;
            end
            step();
        end
        check("tbl_idle_valid", int'(out_valid), 0);
        check("tbl_idle_hold", int'(out_data), 7'h3F);
        check("tbl_word_cnt", int'(word_cnt), 11);
        check("tbl_inj_cnt", int'(inj_cnt), n_inj);

        // Backpressure: fill output and skid, third word must be refused.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h1; step();
        in_data = 4'h2; step();
        check("bp_in_ready_full", int'(in_ready), 0);
        in_data = 4'h3; step();
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_data", int'(out_data), 7'h07);
        check("bp_in_ready_held", int'(in_ready), 0);
        out_ready = 1'b1; step();
        check("bp_drain_skid", int'(out_data), 7'h19);
        check("bp_in_ready_back", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp_third_word", int'(out_data), 7'h1E);
        step();
        check("bp_empty", int'(out_valid), 0);
        check("bp_sb_empty", exp_q.size(), 0);

        // Reset while the skid is full.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 4'h4; step();
        in_data = 4'h8; step();
        check("mr_skid_full", int'(in_ready), 0);
        rst_n = 1'b0; in_valid = 1'b0; step();
        check("mr_out_valid", int'(out_valid), 0);
        check("mr_word_cnt", int'(word_cnt), 0);
        check("mr_inj_cnt", int'(inj_cnt), 0);
        check("mr_in_ready", int'(in_ready), 0);
        rst_n = 1'b1; out_ready = 1'b1; step();
        check("mr_in_ready_after", int'(in_ready), 1);

        // 17 corrupted words: 4-bit counters saturate, 16-bit ones do not.
        in_valid = 1'b1; inj_en = 1'b1; inj_pos = 3'd3;
        for (int i = 0; i < 17; i++) begin
            in_data = 4'(i);
            step();
        end
        in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0;
        repeat (2) step();
        check("sat_word_cnt16", int'(word_cnt), 17);
        check("sat_inj_cnt16", int'(inj_cnt), 17);
        check("sat_word_cnt4", int'(s_word_cnt), 15);
        check("sat_inj_cnt4", int'(s_inj_cnt), 15);
        check("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
